mem_read_engine: RTL and testbench
==================================

// Module: mem_read_engine
// PURPOSE
//  Sits upstream of systolic_array_ctrl, one instance per operand (A and B).
//  Pops addresses from the A/B memory-address FIFO, issues read requests to
//  the memory port, buffers returned lines, and writes them into the operand
//  buffer. Its buf_wr_en output drives systolic_array_ctrl's a_valid_data /
//  b_valid_data input. Bounds in-flight reads with a credit scheme and reports
//  done once words_total lines have been delivered.
// PARAMETERS
//  MEM_DATA_WIDTH_BYTES  32  width of one memory read line, in bytes
//  MAX_OUTSTANDING       4   max reads in flight; also response FIFO depth (power of 2, >=2)
// PORTS
//  clk          in   1        clock; all logic on rising edge
//  reset_n      in   1        asynchronous active-low reset
//  start_i      in   1        start pulse; sampled in IDLE only
//  words_total  in   16       lines to deliver; sampled when start_i is accepted
//  clear        in   1        abort/flush (wired to data_done)
//  fifo_addr    in   16       head of the address FIFO
//  fifo_empty   in   1        address FIFO is empty
//  fifo_pop     out  1        pop the address FIFO this cycle
//  mem_req      out  1        read request valid
//  mem_addr     out  16       read address
//  mem_gnt      in   1        request accepted when mem_req & mem_gnt
//  mem_rvalid   in   1        read data valid; responses return in order
//  mem_rdata    in   8*MEM_DATA_WIDTH_BYTES   read data
//  buf_ready    in   1        operand buffer can accept a write
//  buf_wr_en    out  1        buffer write strobe (-> a_valid_data/b_valid_data)
//  buf_wr_data  out  8*MEM_DATA_WIDTH_BYTES   buffer write data
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse: all lines delivered
// BEHAVIOUR
//  Reset: state=IDLE; fifo_pop, mem_req, buf_wr_en, busy, done = 0;
//   mem_addr, buf_wr_data = 0; all counters and the response FIFO are empty.
//  FSM IDLE -> RUN on start_i: latch words_total; clear the issued,
//   outstanding, and delivered counters.
//  FSM RUN -> IDLE: when delivered == total, pulse done for one cycle.
//   words_total=0 gives done the cycle after start, with no requests issued.
//  FSM RUN/IDLE -> FLUSH on clear (clear has priority over every other event).
//  FSM FLUSH -> IDLE: once no request is pending and outstanding == 0.
//   start_i is ignored in FLUSH. No done pulse after a clear.
//  Issue: fifo_pop = RUN & ~fifo_empty & issued<total & credit & slot_free.
//   slot_free = ~mem_req | mem_gnt.
//   credit = (mem_req + outstanding + resp_fifo_count) < MAX_OUTSTANDING.
//   On pop, mem_req=1 and mem_addr=fifo_addr on the next cycle.
//   mem_req and mem_addr stay stable until mem_gnt.
//   Back-to-back issue, one request per cycle, when mem_gnt stays high.
//  Outstanding: +1 on mem_req&mem_gnt, -1 on mem_rvalid; both in one cycle
//   leaves it unchanged. Width is clog2(MAX_OUTSTANDING)+1.
//  Response path: mem_rvalid writes mem_rdata into the response FIFO.
//   Overflow cannot occur because of the credit rule; assert if it does.
//   buf_wr_en = RUN & ~resp_empty & buf_ready (combinational).
//   buf_wr_data = FIFO head. Each write pops the FIFO and increments delivered.
//   Minimum latency mem_rvalid -> buf_wr_en is 1 cycle. Simultaneous push and
//   pop on the FIFO is allowed, including when it is full.
//  Clear (RUN or FLUSH): fifo_pop forced to 0, and the response FIFO is flushed
//   the same cycle. A pending mem_req is held until granted, never withdrawn.
//   Later mem_rvalid data is discarded. buf_wr_en = 0 from the clear cycle on.
//  Reset mid-operation: immediate return to the reset values; any responses
//   still in flight must be absent, which is the system's responsibility.
//  Counters are 16 bit; words_total=0xFFFF must be supported with no wrap.
// TESTING
//  T1 words_total=4, gnt=1, rvalid 2 cycles after gnt, buf_ready=1 ->
//     4 pops, 4 reqs, 4 buf_wr_en in address order, done 1 cycle after the 4th write.
//  T2 gnt=1, rvalid delayed 20 cycles, words_total=8 ->
//     no more than 4 reqs in flight; req resumes the cycle after a credit returns.
//  T3 buf_ready=0 for 30 cycles, words_total=6 -> resp FIFO fills to 4 and
//     issuing stalls; no data lost; all 6 written in order after buf_ready=1.
//  T4 gnt low 3 cycles during a request -> mem_req and mem_addr stable across
//     those 3 cycles; exactly one pop per address.
//  T5 clear with 3 reads outstanding and 1 line queued -> queue dropped,
//     no buf_wr_en; FLUSH until the 3 rvalids return, then IDLE; no done;
//     a new start works normally.
//  T6 words_total=0 -> done the cycle after start_i, no fifo_pop and no mem_req.

Source files
------------

// File: rtl/mem_read_engine_if.sv
// rtl/mem_read_engine_if.sv - memory read port between a read engine and its memory
interface mem_read_engine_if #(
    parameter int DATA_W = 256
);
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/mem_read_engine.sv
// rtl/mem_read_engine.sv - credit-bounded operand line fetcher feeding the systolic operand buffer
module mem_read_engine #(
    parameter int MEM_DATA_WIDTH_BYTES = 32,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_i,
    input  logic [15:0]                       words_total,
    input  logic                              clear,
    input  logic [15:0]                       fifo_addr,
    input  logic                              fifo_empty,
    output logic                              fifo_pop,
    mem_read_engine_if.master                 mem,
    input  logic                              buf_ready,
    output logic                              buf_wr_en,
    output logic [8*MEM_DATA_WIDTH_BYTES-1:0] buf_wr_data,
    output logic                              busy,
    output logic                              done
);
    localparam int DW = 8 * MEM_DATA_WIDTH_BYTES;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        state;
    logic [15:0]   total;
    logic [15:0]   issued;
    logic [15:0]   delivered;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] resp_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] resp_mem [MAX_OUTSTANDING];

    logic          run;
    logic          granted;
    logic          slot_free;
    logic          credit;
    logic [CW+1:0] in_use;
    logic          resp_empty;
    logic          resp_full;
    logic          resp_push;
    logic          resp_pop;

    // clear wins over everything, so it masks issue and delivery in the same cycle
    assign run       = (state == S_RUN) && !clear;
    assign granted   = mem.mem_req && mem.mem_gnt;
    assign slot_free = !mem.mem_req || mem.mem_gnt;
    assign in_use    = (CW+2)'(mem.mem_req) + (CW+2)'(outstanding) + (CW+2)'(resp_count);
    assign credit    = in_use < (CW+2)'(MAX_OUTSTANDING);
    assign fifo_pop  = run && !fifo_empty && (issued < total) && credit && slot_free;

    assign resp_empty  = (resp_count == '0);
    assign resp_full   = (resp_count == CW'(MAX_OUTSTANDING));
    assign buf_wr_en   = run && !resp_empty && buf_ready;
    assign resp_pop    = buf_wr_en;
    assign resp_push   = run && mem.mem_rvalid;
    assign buf_wr_data = resp_empty ? '0 : resp_mem[rd_ptr];
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            total        <= '0;
            issued       <= '0;
            delivered    <= '0;
            done         <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            done <= 1'b0;
            // a request is held until granted, even across a clear
            if (fifo_pop) begin
                mem.mem_req  <= 1'b1;
                mem.mem_addr <= fifo_addr;
            end else if (mem.mem_gnt) begin
                mem.mem_req <= 1'b0;
            end
            if (fifo_pop) begin
                issued <= issued + 16'd1;
            end
            if (buf_wr_en) begin
                delivered <= delivered + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        state <= S_FLUSH;
                    end else if (start_i) begin
                        total     <= words_total;
                        issued    <= '0;
                        delivered <= '0;
                        if (words_total == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (clear) begin
                        state <= S_FLUSH;
                    end else if (buf_wr_en && (delivered + 16'd1 == total)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (!clear && !mem.mem_req && (outstanding == '0)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            resp_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case ({granted, mem.mem_rvalid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (clear) begin
                resp_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (resp_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (resp_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                resp_count <= resp_count + CW'(resp_push) - CW'(resp_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_push) begin
            resp_mem[wr_ptr] <= mem.mem_rdata;
        end
    end

    // the credit rule keeps the response FIFO from ever overflowing
    assert property (@(posedge clk) disable iff (!reset_n) !(resp_push && resp_full && !resp_pop));
endmodule

// File: tb/tb_mem_read_engine.sv
// tb/tb_mem_read_engine.sv - scoreboard bench for mem_read_engine
module tb_mem_read_engine;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_i = 1'b0;
    logic [15:0]  words_total = '0;
    logic         clear = 1'b0;
    logic [15:0]  fifo_addr = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_pop;
    logic         buf_ready = 1'b0;
    logic         buf_wr_en;
    logic [255:0] buf_wr_data;
    logic         busy;
    logic         done;

    mem_read_engine_if #(.DATA_W(256)) mif();

    mem_read_engine #(.MEM_DATA_WIDTH_BYTES(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .words_total(words_total),
        .clear(clear), .fifo_addr(fifo_addr), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .mem(mif), .buf_ready(buf_ready), .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;
    int cyc = 0, lat = 2, br_on_cyc = 0, job_total = 0;
    int n_pop, n_req, n_wr, n_done, n_rv, n_hold, max_inflight, max_queued, queued;
    int done_cyc, last_wr_cyc, start_cyc, last_rv_cyc, gnt_low_left = 0;
    bit start_req = 0, clr_arm = 0, flushing = 0, gnt_stall_req = 0, prev_hold = 0;
    logic [15:0]  prev_addr;
    logic [15:0]  addr_q[$];
    logic [15:0]  iss_q[$];
    logic [15:0]  rd_q[$];
    int           due_q[$];
    logic [255:0] exp_q[$];

    function automatic logic [255:0] data_of(input logic [15:0] a);
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[i*16 +: 16] = a ^ (16'(i) * 16'h1111);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic reset_model();
        n_pop = 0; n_req = 0; n_wr = 0; n_done = 0; n_rv = 0; n_hold = 0;
        max_inflight = 0; max_queued = 0; queued = 0; flushing = 0; prev_hold = 0;
        done_cyc = -1; last_wr_cyc = -1; start_cyc = -1; last_rv_cyc = -1;
        gnt_stall_req = 0; clr_arm = 0;
        addr_q.delete(); iss_q.delete(); exp_q.delete();
    endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = base + 16'(i) * 16'h40;
            addr_q.push_back(a);
            exp_q.push_back(data_of(a));
        end
    endtask

    task automatic cycle();
        bit           rv;
        logic [15:0]  exp_addr;
        logic [255:0] exp_d;
        logic [15:0]  t16;
        int           ti;
        @(negedge clk);
        start_i     = start_req;
        words_total = 16'(job_total);
        clear       = 1'b0;
        if (clr_arm && n_rv == 1) begin
            clear = 1'b1; clr_arm = 0; flushing = 1;
            chk("clr_inflight", rd_q.size(), 3);
            chk("clr_queued", queued, 1);
            queued = 0;
            br_on_cyc = cyc;
        end
        fifo_empty = (addr_q.size() == 0);
        fifo_addr  = fifo_empty ? 16'h0 : addr_q[0];
        buf_ready  = (cyc >= br_on_cyc);
        if (gnt_stall_req && mif.mem_req) begin gnt_low_left = 3; gnt_stall_req = 0; end
        mif.mem_gnt = (gnt_low_left == 0);
        if (gnt_low_left > 0) gnt_low_left--;
        rv = (due_q.size() > 0) && (due_q[0] <= cyc);
        mif.mem_rvalid = rv;
        mif.mem_rdata  = rv ? data_of(rd_q[0]) : '0;
        #1;
        if (start_i) begin start_cyc = cyc; start_req = 0; end
        if (fifo_pop) begin
            n_pop++;
            if (addr_q.size() > 0) iss_q.push_back(addr_q.pop_front());
        end
        if (rv) begin
            t16 = rd_q.pop_front(); ti = due_q.pop_front();
            n_rv++; last_rv_cyc = cyc;
            if (!flushing) queued++;
        end
        if (prev_hold) begin
            chk("hold_req", mif.mem_req, 1'b1);
            chk("hold_addr", mif.mem_addr, prev_addr);
        end
        prev_hold = mif.mem_req && !mif.mem_gnt;
        prev_addr = mif.mem_addr;
        if (prev_hold) n_hold++;
        if (mif.mem_req && mif.mem_gnt) begin
            n_req++;
            if (iss_q.size() > 0) exp_addr = iss_q.pop_front();
            else exp_addr = 16'hDEAD;
            chk("req_addr", mif.mem_addr, exp_addr);
            rd_q.push_back(mif.mem_addr);
            due_q.push_back(cyc + lat);
        end
        if (buf_wr_en) begin
            n_wr++; queued--; last_wr_cyc = cyc;
            if (exp_q.size() > 0) exp_d = exp_q.pop_front();
            else exp_d = '1;
            chk("wr_data", buf_wr_data, exp_d);
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (rd_q.size() > max_inflight) max_inflight = rd_q.size();
        if (queued > max_queued) max_queued = queued;
        cyc++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin cycle(); k++; end
        chk(tag, n_done != 0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        mif.mem_gnt = 1'b1; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        reset_model();
        repeat (3) cycle();
        chk("rst_pop", fifo_pop, 1'b0);
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_addr", mif.mem_addr, 16'h0);
        chk("rst_wr_en", buf_wr_en, 1'b0);
        chk("rst_wr_data", buf_wr_data, 256'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset_n = 1'b1;
        repeat (2) cycle();

        // T1: basic in-order delivery
        reset_model(); lat = 2; br_on_cyc = 0;
        load(4, 16'h0100); job_total = 4; start_req = 1;
        wait_done("t1_done", 200);
        chk("t1_pops", n_pop, 4);
        chk("t1_reqs", n_req, 4);
        chk("t1_writes", n_wr, 4);
        chk("t1_done_lat", done_cyc, last_wr_cyc + 1);
        chk("t1_sb_empty", exp_q.size(), 0);
        repeat (3) cycle();
        chk("t1_done_once", n_done, 1);
        chk("t1_busy", busy, 1'b0);

        // T2: long read latency bounded by credits
        reset_model(); lat = 20;
        load(8, 16'h2000); job_total = 8; start_req = 1;
        wait_done("t2_done", 600);
        chk("t2_max_inflight", max_inflight, 4);
        chk("t2_reqs", n_req, 8);
        chk("t2_writes", n_wr, 8);
        chk("t2_sb_empty", exp_q.size(), 0);
        repeat (2) cycle();

        // T3: buffer back-pressure fills the response FIFO
        reset_model(); lat = 2; br_on_cyc = cyc + 30;
        load(6, 16'h3000); job_total = 6; start_req = 1;
        repeat (30) cycle();
        chk("t3_queued", max_queued, 4);
        chk("t3_stall_reqs", n_req, 4);
        chk("t3_no_write", n_wr, 0);
        wait_done("t3_done", 300);
        chk("t3_writes", n_wr, 6);
        chk("t3_sb_empty", exp_q.size(), 0);
        repeat (2) cycle();

        // T4: grant withheld for three cycles
        reset_model(); lat = 2; br_on_cyc = 0; gnt_stall_req = 1;
        load(3, 16'h4000); job_total = 3; start_req = 1;
        wait_done("t4_done", 200);
        chk("t4_hold_cycles", n_hold, 3);
        chk("t4_pops", n_pop, 3);
        chk("t4_reqs", n_req, 3);
        chk("t4_writes", n_wr, 3);
        repeat (2) cycle();

        // T5: clear with reads in flight, then a fresh job
        reset_model(); lat = 10; br_on_cyc = 1 << 30; clr_arm = 1;
        load(8, 16'h5000); job_total = 8; start_req = 1;
        k = 0;
        do begin cycle(); k++; end
        while ((clr_arm || busy || rd_q.size() > 0) && k < 300);
        chk("t5_cleared", clr_arm, 1'b0);
        chk("t5_idle_lat", cyc - 1, last_rv_cyc + 2);
        chk("t5_rvalids", n_rv, 4);
        repeat (4) cycle();
        chk("t5_no_write", n_wr, 0);
        chk("t5_no_done", n_done, 0);
        reset_model(); lat = 2; br_on_cyc = 0;
        load(3, 16'h6000); job_total = 3; start_req = 1;
        wait_done("t5_restart_done", 200);
        chk("t5_restart_writes", n_wr, 3);
        chk("t5_restart_sb", exp_q.size(), 0);
        repeat (2) cycle();

        // T6: zero-length job
        reset_model(); lat = 2;
        load(2, 16'h7000); job_total = 0; start_req = 1;
        repeat (6) cycle();
        chk("t6_done_lat", done_cyc, start_cyc + 1);
        chk("t6_done_once", n_done, 1);
        chk("t6_pops", n_pop, 0);
        chk("t6_reqs", n_req, 0);
        chk("t6_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
